iob_fifo2axis: RTL and testbench
================================

// Module: iob_fifo2axis
// PURPOSE
//  Reader/drain end of iob_fifo_sync: pops words from a sync FIFO read port and presents them as a
//  valid/ready stream with tlast framing. Absorbs the 1-cycle FIFO read latency, sustains 1 word/cycle,
//  and never drops or duplicates a word under arbitrary backpressure. Sits between a FIFO and a DMA/stream sink.
// PARAMETERS
//  DATA_W  32  word width; equals R_DATA_W of the attached FIFO
//  LEN_W   16  width of frame-length input and beat counter
// PORTS
//  clk           in   1       clock, rising edge
//  arst_n        in   1       asynchronous reset, active-low
//  en            in   1       1: issue FIFO reads; 0: stop reading, buffered words still drain
//  len           in   LEN_W   frame length in words; 0 = unframed, tlast never asserted
//  fifo_r_en     out  1       FIFO read strobe; data returns next cycle
//  fifo_r_data   in   DATA_W  FIFO read data, valid the cycle after fifo_r_en
//  fifo_r_empty  in   1       FIFO empty flag
//  axis_tvalid   out  1       output word valid
//  axis_tready   in   1       sink accepts the word
//  axis_tdata    out  DATA_W  output word
//  axis_tlast    out  1       last word of frame
//  frame_done    out  1       1-cycle pulse after the tlast beat is accepted
// BEHAVIOUR
//  - Reset (arst_n=0): buffer empty, rd_pend=0, cnt=0; axis_tvalid=0, axis_tdata=0, axis_tlast=0,
//    frame_done=0. fifo_r_en is forced to 0 while arst_n=0.
//  - pop = axis_tvalid & axis_tready. occ = buf_count + rd_pend, range 0..2.
//  - fifo_r_en = en & ~fifo_r_empty & ((occ - pop) < 2). This is combinational. rd_pend <= fifo_r_en.
//  - Cycle after fifo_r_en: fifo_r_data is written to the 2-entry buffer tail.
//    Same-cycle push and pop are both honoured.
//  - Latency: fifo_r_en in cycle N -> axis_tvalid in cycle N+2 (output is registered from the buffer head).
//  - Throughput: with tready=1 and the FIFO non-empty, one word per cycle steady state.
//  - Backpressure: tdata, tlast and tvalid stay stable while tvalid=1 and tready=0. buf_count never exceeds 2.
//  - Framing: cnt counts accepted beats. len_eff = (cnt==0) ? len : len_q; len_q is latched on the first pop of a frame.
//    - axis_tlast = axis_tvalid & (len_eff!=0) & (cnt==len_eff-1).
//    - On a pop with tlast: cnt<=0 and frame_done pulses the next cycle. Otherwise a pop increments cnt.
//    - len=1 gives tlast on every beat. len changes mid-frame are ignored until cnt returns to 0.
//  - fifo_r_empty mid-frame: tvalid drops when the buffer drains. cnt holds. Framing resumes exactly on refill.
//  - en=0 mid-frame: no new reads. At most 2 more words are emitted (buffer plus in-flight). cnt holds for re-enable.
//  - Reset mid-frame: the in-flight word and buffered words are discarded, and cnt is cleared.
//    The FIFO must be reset together with this block.
//  - Width rules: cnt is LEN_W bits. len_eff-1 is evaluated only when len_eff!=0, so it never wraps.
// STRUCTURE
//  - Shared header iob_fifo2axis.vh: none needed beyond iob_lib.vh macros (IOB_REG_AR style registers).
//  - Sub-module iob_fifo2axis_buf: 2-entry register FIFO with push, pop, count[1:0], head data/valid,
//    and arst_n. The top level holds the read-issue logic, rd_pend, the beat counter, len_q, tlast and frame_done.
// TESTING (DATA_W=32, LEN_W=16, iob_fifo_sync ADDR_W=4 attached)
//  1. Preload 8 words 0..7, len=4, tready=1, en=1.
//     -> tdata 0..7 on consecutive cycles; first tvalid 2 cycles after first fifo_r_en;
//        tlast on words 3 and 7; frame_done pulses twice.
//  2. 16 words, tready toggling 1,0,1,0...
//     -> output 0..15 in order with no loss or duplication; tdata stable while stalled.
//  3. FIFO full, tready=0 for 10 cycles.
//     -> exactly 2 fifo_r_en pulses, then fifo_r_en=0. Set tready=1 -> stream continues at 1 word/cycle.
//  4. len=4, 2 words available, then 6 more after 5 idle cycles.
//     -> tvalid gap during the idle cycles; tlast exactly on the 4th and 8th beats.
//  5. en=0 after 2 beats, with buffer and in-flight full.
//     -> at most 2 more beats, no further reads. en=1 -> tlast still on the frame's 4th beat.
//  6. arst_n low for 1 cycle mid-frame.
//     -> tvalid, tlast, frame_done and fifo_r_en are 0. After release, the first beat restarts the count.
//     Also len=1: tlast on every beat. len=0: tlast never asserted over 20 beats.

Source files
------------

// File: rtl/iob_fifo2axis_pkg.sv
// Shared types and helpers for the FIFO-to-stream drain block.
package iob_fifo2axis_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Occupancy left once this cycle's pop has been taken; gates issuing another read.
    function automatic occ_t occ_after_pop(input occ_t occ, input logic pop);
        return occ - occ_t'(pop);
    endfunction

endpackage

// File: rtl/iob_fifo2axis_buf.sv
// Two-entry register FIFO that absorbs the read latency of the upstream FIFO.
module iob_fifo2axis_buf
    import iob_fifo2axis_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output occ_t              count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop & head_valid;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push    = push & ((count < occ_t'(BUF_DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + occ_t'(1);
                2'b01:   count <= count - occ_t'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iob_fifo2axis.sv
// Drains a sync FIFO read port into a valid/ready stream with tlast framing.
module iob_fifo2axis
    import iob_fifo2axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [LEN_W-1:0]  len,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_r_data,
    input  logic              fifo_r_empty,
    output logic              axis_tvalid,
    input  logic              axis_tready,
    output logic [DATA_W-1:0] axis_tdata,
    output logic              axis_tlast,
    output logic              frame_done
);

    logic             rd_pend;
    occ_t             buf_count;
    occ_t             occ;
    logic             pop;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;

    assign pop = axis_tvalid & axis_tready;
    assign occ = buf_count + occ_t'(rd_pend);

    // Reads are issued only while the buffer plus the in-flight word can still take one more.
    assign fifo_r_en = arst_n & en & ~fifo_r_empty
                     & (occ_after_pop(occ, pop) < occ_t'(BUF_DEPTH));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_r_en;
        end
    end

    iob_fifo2axis_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (rd_pend),
        .push_data  (fifo_r_data),
        .pop        (pop),
        .count      (buf_count),
        .head_data  (axis_tdata),
        .head_valid (axis_tvalid)
    );

    // The frame length is sampled live until the first beat, then frozen for the frame.
    assign len_eff    = (cnt == '0) ? len : len_q;
    assign axis_tlast = axis_tvalid & (len_eff != '0) & (cnt == len_eff - LEN_W'(1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt        <= '0;
            len_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & axis_tlast;
            if (pop) begin
                if (cnt == '0) begin
                    len_q <= len;
                end
                if (axis_tlast) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Directed bench: queue-based FIFO and stream model with per-cycle output checks.
module tb_iob_fifo2axis;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              en = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_r_data = '0;
    logic              fifo_r_empty;
    logic              axis_tvalid;
    logic              axis_tready = 1'b0;
    logic [DATA_W-1:0] axis_tdata;
    logic              axis_tlast;
    logic              frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_fifo2axis #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .en           (en),
        .len          (len),
        .fifo_r_en    (fifo_r_en),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_empty (fifo_r_empty),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tdata   (axis_tdata),
        .axis_tlast   (axis_tlast),
        .frame_done   (frame_done)
    );

    // Upstream FIFO model: data appears the cycle after the read strobe, flushed by reset.
    logic [DATA_W-1:0] fmem [256];
    int f_wr = 0;
    int f_rd = 0;
    assign fifo_r_empty = (f_rd == f_wr);

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            f_rd <= f_wr;
        end else if (fifo_r_en) begin
            fifo_r_data <= fmem[f_rd % 256];
            f_rd        <= f_rd + 1;
        end
    end

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic              last;
    } pop_t;

    logic [DATA_W-1:0] exp_q [$];
    pop_t              pop_log [$];
    int                rd_log [$];
    int                mon_cyc = 0;
    int                tot_pops = 0;
    int                tot_last = 0;
    int                tot_done = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Stream model: words leave in FIFO order; tlast comes from a beat count against the frame length.
    int                beat_m = 0;
    int                len_m = 0;
    int                cur_len;
    logic              exp_last;
    logic              pend_done = 1'b0;
    int                outstanding = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    logic              stall_last = 1'b0;

    always @(negedge clk) begin
        mon_cyc++;
        if (!arst_n) begin
            chk("rst_tvalid", axis_tvalid, 0);
            chk("rst_tlast", axis_tlast, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_fifo_r_en", fifo_r_en, 0);
            chk("rst_tdata", axis_tdata, 0);
            exp_q.delete();
            beat_m      = 0;
            len_m       = 0;
            pend_done   = 1'b0;
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            chk("frame_done", frame_done, pend_done);
            pend_done = 1'b0;
            if (frame_done) tot_done++;
            if (fifo_r_en && fifo_r_empty) chk("read_when_empty", 1, 0);
            if (stall_prev) begin
                chk("stall_tvalid", axis_tvalid, 1);
                chk("stall_tdata", axis_tdata, stall_data);
                chk("stall_tlast", axis_tlast, stall_last);
            end
            cur_len  = (beat_m == 0) ? int'(len) : len_m;
            exp_last = (cur_len != 0) && (beat_m == cur_len - 1);
            if (axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("tvalid_without_word", 1, 0);
                end else begin
                    chk("tdata", axis_tdata, exp_q[0]);
                end
                chk("tlast", axis_tlast, exp_last);
            end else begin
                chk("tlast_idle", axis_tlast, 0);
            end
            if (fifo_r_en) begin
                rd_log.push_back(mon_cyc);
                outstanding++;
            end
            if (axis_tvalid && axis_tready) begin
                pop_log.push_back('{mon_cyc, axis_tdata, axis_tlast});
                tot_pops++;
                if (axis_tlast) tot_last++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                outstanding--;
                if (beat_m == 0) len_m = int'(len);
                if (exp_last) begin
                    beat_m    = 0;
                    pend_done = 1'b1;
                end else begin
                    beat_m++;
                end
            end
            chk("occupancy_le_2", (outstanding <= 2), 1);
            stall_prev = axis_tvalid & ~axis_tready;
            stall_data = axis_tdata;
            stall_last = axis_tlast;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fmem[f_wr % 256] = w;
        exp_q.push_back(w);
        f_wr++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc_wait(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
        cyc_wait(3);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (tot_pops < target && n < 100) begin
            cyc_wait(1);
            n++;
        end
        chk("pop_wait", (tot_pops >= target), 1);
    endtask

    function automatic int last_mask(input int from, input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (from + i < pop_log.size() && pop_log[from + i].last) m |= (1 << i);
        end
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int p0, r0, d0, q1, r1, l0;
        len = 16'd4;
        cyc_wait(3);
        arst_n = 1'b1;

        // 1: eight words, len=4, full rate
        for (int i = 0; i < 8; i++) push_word(i);
        axis_tready = 1'b1;
        p0 = pop_log.size();
        r0 = rd_log.size();
        d0 = tot_done;
        en = 1'b1;
        drain("t1_drain");
        chk("t1_pop_count", pop_log.size() - p0, 8);
        if (pop_log.size() >= p0 + 8 && rd_log.size() > r0) begin
            chk("t1_latency", pop_log[p0].cyc - rd_log[r0], 2);
            chk("t1_first_word", pop_log[p0].data, 0);
            chk("t1_last_word", pop_log[p0 + 7].data, 7);
            chk("t1_back_to_back", pop_log[p0 + 7].cyc - pop_log[p0].cyc, 7);
        end
        chk("t1_tlast_mask", last_mask(p0, 8), 'h88);
        chk("t1_frame_done", tot_done - d0, 2);

        // 2: sixteen words under alternating backpressure
        p0 = pop_log.size();
        for (int i = 0; i < 16; i++) push_word(i);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            axis_tready = ~axis_tready;
            cyc_wait(1);
        end
        axis_tready = 1'b1;
        drain("t2_drain");
        chk("t2_pop_count", pop_log.size() - p0, 16);
        if (pop_log.size() >= p0 + 16) chk("t2_last_word", pop_log[p0 + 15].data, 15);

        // 3: full FIFO, sink stalled for 10 cycles
        axis_tready = 1'b0;
        r0 = rd_log.size();
        for (int i = 0; i < 16; i++) push_word(32'h40 + i);
        cyc_wait(10);
        chk("t3_reads_while_stalled", rd_log.size() - r0, 2);
        chk("t3_r_en_low", fifo_r_en, 0);
        p0 = pop_log.size();
        axis_tready = 1'b1;
        drain("t3_drain");
        chk("t3_pop_count", pop_log.size() - p0, 16);
        if (pop_log.size() >= p0 + 16)
            chk("t3_back_to_back", pop_log[p0 + 15].cyc - pop_log[p0].cyc, 15);

        // 4: two words, idle gap, six more
        p0 = pop_log.size();
        push_word(32'h80);
        push_word(32'h81);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc_wait(1);
        cyc_wait(2);
        chk("t4_gap_tvalid", axis_tvalid, 0);
        cyc_wait(3);
        for (int i = 2; i < 8; i++) push_word(32'h80 + i);
        drain("t4_drain");
        chk("t4_tlast_mask", last_mask(p0, 8), 'h88);

        // 5: en dropped after two beats
        p0 = pop_log.size();
        for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
        wait_pops(tot_pops + 2);
        en = 1'b0;
        r1 = rd_log.size();
        q1 = tot_pops;
        cyc_wait(8);
        chk("t5_reads_while_off", rd_log.size() - r1, 0);
        chk("t5_extra_beats_le_2", (tot_pops - q1 <= 2), 1);
        en = 1'b1;
        drain("t5_drain");
        chk("t5_tlast_mask", last_mask(p0, 8), 'h88);

        // 6: reset mid-frame, then len=1 and len=0
        for (int i = 0; i < 8; i++) push_word(32'hC0 + i);
        wait_pops(tot_pops + 2);
        arst_n = 1'b0;
        cyc_wait(1);
        arst_n = 1'b1;
        p0 = pop_log.size();
        for (int i = 0; i < 8; i++) push_word(32'h100 + i);
        drain("t6_drain");
        if (pop_log.size() > p0) chk("t6_first_after_reset", pop_log[p0].data, 'h100);
        chk("t6_tlast_mask", last_mask(p0, 8), 'h88);

        len = 16'd1;
        p0 = pop_log.size();
        d0 = tot_done;
        for (int i = 0; i < 5; i++) push_word(32'h200 + i);
        drain("len1_drain");
        chk("len1_tlast_mask", last_mask(p0, 5), 'h1F);
        chk("len1_frame_done", tot_done - d0, 5);

        len = 16'd0;
        p0 = pop_log.size();
        l0 = tot_last;
        for (int i = 0; i < 20; i++) push_word(32'h300 + i);
        drain("len0_drain");
        chk("len0_pop_count", pop_log.size() - p0, 20);
        chk("len0_no_tlast", tot_last - l0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
